// File: rtl/channel_addition_seq_if.sv
// Handshake bundle between the layer controller/core side and the channel-addition sequencer.
// master = sequencer view, slave = controller/core/SRAM view.
interface channel_addition_seq_if #(
    parameter int ADDR_WIDTH    = 16,
    parameter int GRP_CNT_WIDTH = 10
);
    logic                     clk_en;
    logic                     start;
    logic                     quant_mode_cfg;
    logic [GRP_CNT_WIDTH-1:0] num_groups;
    logic [ADDR_WIDTH-1:0]    base_addr;
    logic                     infms_data_vld;

    logic                     sram_rd_en;
    logic [ADDR_WIDTH-1:0]    sram_rd_addr;
    logic                     sram_data_vld;
    logic                     sram_change_vld;
    logic                     chn_add_en;
    logic                     quant_mode;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        input  clk_en, start, quant_mode_cfg, num_groups, base_addr, infms_data_vld,
        output sram_rd_en, sram_rd_addr, sram_data_vld, sram_change_vld, chn_add_en,
               quant_mode, busy, done, err
    );

    modport slave (
        output clk_en, start, quant_mode_cfg, num_groups, base_addr, infms_data_vld,
        input  sram_rd_en, sram_rd_addr, sram_data_vld, sram_change_vld, chn_add_en,
               quant_mode, busy, done, err
    );
endinterface

// File: rtl/channel_addition_seq.sv
// Sequencer feeding channel_addition_core from a single-port feature-map SRAM:
// banked reads, data/change/add strobes, and per-group handshake with the core.
module channel_addition_seq #(
    parameter int ADDR_WIDTH     = 16,
    parameter int GRP_CNT_WIDTH  = 10,
    parameter int BANK_BEATS     = 4,
    parameter int GRP_BEATS_INT4 = 64,
    parameter int GRP_BEATS_INT8 = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    channel_addition_seq_if.master bus
);
    localparam int BANKS_INT4 = GRP_BEATS_INT4 / BANK_BEATS;
    localparam int BANKS_INT8 = GRP_BEATS_INT8 / BANK_BEATS;
    localparam int BANKS_MAX  = (BANKS_INT8 > BANKS_INT4) ? BANKS_INT8 : BANKS_INT4;
    localparam int BANK_W     = $clog2(BANKS_MAX > 1 ? BANKS_MAX : 2);
    localparam int BEAT_W     = $clog2(BANK_BEATS > 1 ? BANK_BEATS : 2);
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_GAP,
        S_CHANGE,
        S_WAIT_CORE,
        S_SETTLE
    } state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [BANK_W-1:0]        bank_q, bank_d;
    logic [GRP_CNT_WIDTH-1:0] grp_left_q, grp_left_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     settle_q, settle_d;
    logic                     after_wait_q, after_wait_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     quant_q, quant_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic                     data_vld_q, data_vld_d;
    logic                     change_q, change_d;
    logic                     chn_q, chn_d;
    logic                     first_q, first_d;
    logic                     done_q, done_d;

    logic                     issue_bank;
    logic [BANK_W-1:0]        last_bank;

    assign last_bank = quant_q ? BANK_W'(BANKS_INT8 - 1) : BANK_W'(BANKS_INT4 - 1);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        bank_d       = bank_q;
        grp_left_d   = grp_left_q;
        tmo_d        = tmo_q;
        settle_d     = settle_q;
        after_wait_d = after_wait_q;
        addr_d       = addr_q;
        quant_d      = quant_q;
        busy_d       = busy_q;
        err_d        = err_q;
        rd_addr_d    = rd_addr_q;
        rd_en_d      = 1'b0;
        change_d     = 1'b0;
        done_d       = 1'b0;
        first_d      = 1'b0;
        issue_bank   = 1'b0;
        data_vld_d   = rd_en_q;
        // first_q marks the read beat whose data opens a new channel group
        chn_d        = rd_en_q & first_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    quant_d = bus.quant_mode_cfg;
                    err_d   = 1'b0;
                    if (bus.num_groups != '0) begin
                        busy_d     = 1'b1;
                        grp_left_d = bus.num_groups;
                        bank_d     = '0;
                        addr_d     = bus.base_addr;
                        first_d    = 1'b1;
                        issue_bank = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (beat_q == BEAT_W'(BANK_BEATS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    beat_d    = beat_q + BEAT_W'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: state_d = S_GAP;
            S_GAP: begin
                state_d  = S_CHANGE;
                change_d = 1'b1;
            end
            S_CHANGE: begin
                if (bank_q == last_bank) begin
                    state_d = S_WAIT_CORE;
                    tmo_d   = '0;
                end else begin
                    bank_d       = bank_q + BANK_W'(1);
                    state_d      = S_SETTLE;
                    settle_d     = 1'b0;
                    after_wait_d = 1'b0;
                end
            end
            S_WAIT_CORE: begin
                if (bus.infms_data_vld) begin
                    state_d      = S_SETTLE;
                    settle_d     = 1'b0;
                    after_wait_d = 1'b1;
                    grp_left_d   = grp_left_q - GRP_CNT_WIDTH'(1);
                    bank_d       = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // core never answered: abandon the remaining groups
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SETTLE: begin
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else if (after_wait_q && (grp_left_q == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    first_d    = after_wait_q;
                    issue_bank = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_bank) begin
            state_d   = S_ISSUE;
            beat_d    = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = addr_d;
            addr_d    = addr_d + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            bank_q       <= '0;
            grp_left_q   <= '0;
            tmo_q        <= '0;
            settle_q     <= 1'b0;
            after_wait_q <= 1'b0;
            addr_q       <= '0;
            quant_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            data_vld_q   <= 1'b0;
            change_q     <= 1'b0;
            chn_q        <= 1'b0;
            first_q      <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.clk_en) begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            bank_q       <= bank_d;
            grp_left_q   <= grp_left_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
            after_wait_q <= after_wait_d;
            addr_q       <= addr_d;
            quant_q      <= quant_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            data_vld_q   <= data_vld_d;
            change_q     <= change_d;
            chn_q        <= chn_d;
            first_q      <= first_d;
            done_q       <= done_d;
        end
    end

    assign bus.sram_rd_en      = rd_en_q;
    assign bus.sram_rd_addr    = rd_addr_q;
    assign bus.sram_data_vld   = data_vld_q;
    assign bus.sram_change_vld = change_q;
    assign bus.chn_add_en      = chn_q;
    assign bus.quant_mode      = quant_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
endmodule

// File: tb/tb_channel_addition_seq.sv
// Scoreboard bench for channel_addition_seq: jobs push expected event times/addresses,
// a negedge monitor pops and compares them as the DUT emits strobes.
module tb_channel_addition_seq;
    localparam int AW  = 16;
    localparam int GW  = 10;
    localparam int TMO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    channel_addition_seq_if #(.ADDR_WIDTH(AW), .GRP_CNT_WIDTH(GW)) bus ();

    channel_addition_seq #(
        .ADDR_WIDTH(AW), .GRP_CNT_WIDTH(GW), .BANK_BEATS(4),
        .GRP_BEATS_INT4(64), .GRP_BEATS_INT8(128), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tick = 0;
    int edge_kind = 3;     // 0 active edge, 1 stalled edge, 2 reset edge
    int rd_t[$];
    logic [AW-1:0] rd_a[$];
    int chg_t[$];
    int chn_t[$];
    int done_t[$];
    logic done_e[$];
    int sched[$];          // ticks on which the emulated core raises infms_data_vld
    int busy_lo = 1;
    int busy_hi = 0;
    logic exp_mode = 1'b0;
    int rd_count = 0;
    logic prev_rd = 1'b0;
    logic [AW+7:0] snap = '0;
    int mon_t;
    logic [AW-1:0] mon_a;
    logic mon_e;

    function automatic logic [AW+7:0] outs();
        return {bus.sram_rd_en, bus.sram_rd_addr, bus.sram_data_vld, bus.sram_change_vld,
                bus.chn_add_en, bus.quant_mode, bus.busy, bus.done, bus.err};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at tick %0d", name, act, exp, tick);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) edge_kind <= 2;
        else if (bus.clk_en) begin
            edge_kind <= 0;
            tick <= tick + 1;
        end else edge_kind <= 1;
    end

    always @(negedge clk) begin
        case (edge_kind)
            2: begin
                check("reset_outputs", outs(), '0);
                prev_rd = 1'b0;
            end
            1: check("stall_hold", outs(), snap);
            0: begin
                check("data_vld_delay", bus.sram_data_vld, prev_rd);
                if (bus.sram_rd_en) begin
                    rd_count++;
                    check("rd_expected", rd_t.size() > 0, 1);
                    if (rd_t.size() > 0) begin
                        mon_t = rd_t.pop_front();
                        mon_a = rd_a.pop_front();
                        check("rd_tick", tick, mon_t);
                        check("rd_addr", bus.sram_rd_addr, mon_a);
                    end
                end
                if (bus.sram_change_vld) begin
                    check("chg_expected", chg_t.size() > 0, 1);
                    if (chg_t.size() > 0) begin
                        mon_t = chg_t.pop_front();
                        check("chg_tick", tick, mon_t);
                    end
                end
                if (bus.chn_add_en) begin
                    check("chn_expected", chn_t.size() > 0, 1);
                    if (chn_t.size() > 0) begin
                        mon_t = chn_t.pop_front();
                        check("chn_tick", tick, mon_t);
                    end
                end
                if (bus.done) begin
                    check("done_expected", done_t.size() > 0, 1);
                    if (done_t.size() > 0) begin
                        mon_t = done_t.pop_front();
                        mon_e = done_e.pop_front();
                        check("done_tick", tick, mon_t);
                        check("done_err", bus.err, mon_e);
                    end
                end
                check("busy", bus.busy, (tick >= busy_lo) && (tick <= busy_hi));
                if ((tick >= busy_lo) && (tick <= busy_hi))
                    check("quant_mode", bus.quant_mode, exp_mode);
                prev_rd = bus.sram_rd_en;
                $display("tick %0d rd=%0b addr=%04h dv=%0b chg=%0b chn=%0b busy=%0b done=%0b err=%0b",
                         tick, bus.sram_rd_en, bus.sram_rd_addr, bus.sram_data_vld,
                         bus.sram_change_vld, bus.chn_add_en, bus.busy, bus.done, bus.err);
            end
            default: ;
        endcase
        snap = outs();
    end

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        while (sched.size() > 0 && sched[0] < tick) void'(sched.pop_front());
        bus.infms_data_vld = (sched.size() > 0) && (sched[0] == tick);
    endtask

    task automatic flush();
        rd_t.delete(); rd_a.delete(); chg_t.delete(); chn_t.delete();
        done_t.delete(); done_e.delete(); sched.delete();
        bus.infms_data_vld = 1'b0;
    endtask

    // Expected behaviour from the bank/group timing rules: cycle 0 = start sampled,
    // bank b of a group reads at org+1+9b..org+4+9b, changes at org+7+9b.
    task automatic run_job(input logic mode, input int groups, input logic [AW-1:0] base,
                           input int w, input bit tmo, input int stall_at, input int rst_at);
        int b0, org, c, nb, exp_reads, cyc, budget;
        bit spur_done;
        logic [AW-1:0] a;
        b0 = tick; org = tick; nb = mode ? 32 : 16; exp_reads = 0; a = base; spur_done = 0;
        if (groups == 0) begin
            done_t.push_back(b0 + 1); done_e.push_back(1'b0);
            busy_lo = b0 + 1; busy_hi = b0;
        end else begin
            sched.push_back(b0 + 3);   // spurious core valid during ISSUE, must be ignored
            for (int g = 0; g < groups; g++) begin
                chn_t.push_back(org + 2);
                for (int b = 0; b < nb; b++) begin
                    for (int k = 0; k < 4; k++) begin
                        rd_t.push_back(org + 1 + 9*b + k);
                        rd_a.push_back(a);
                        a = a + AW'(1);
                        exp_reads++;
                    end
                    chg_t.push_back(org + 7 + 9*b);
                end
                c = org + 7 + 9*(nb - 1);
                if (tmo) begin
                    done_t.push_back(c + 1 + TMO); done_e.push_back(1'b1);
                    break;
                end
                sched.push_back(c + w);
                if (g == groups - 1) begin
                    done_t.push_back(c + w + 3); done_e.push_back(1'b0);
                end else org = c + w + 2;
            end
            busy_lo = b0 + 1;
            busy_hi = done_t[done_t.size()-1] - 1;
        end
        exp_mode = mode;
        rd_count = 0;
        $display("job mode=%0d groups=%0d base=%04h w=%0d tmo=%0d stall=%0d rst=%0d",
                 mode, groups, base, w, tmo, stall_at, rst_at);
        bus.start = 1'b1; bus.quant_mode_cfg = mode;
        bus.num_groups = GW'(groups); bus.base_addr = base;
        tick_cycle();
        bus.start = 1'b0;
        bus.quant_mode_cfg = 1'($urandom);
        bus.num_groups = GW'($urandom);
        bus.base_addr = AW'($urandom);
        @(negedge clk);
        check("err_cleared_on_start", bus.err, 1'b0);
        budget = 0;
        while (done_t.size() > 0 && budget < 6000) begin
            cyc = tick - b0;
            if (stall_at > 0 && cyc == stall_at) begin
                bus.clk_en = 1'b0;
                repeat (3) tick_cycle();
                bus.clk_en = 1'b1;
                stall_at = 0;
            end
            if (!spur_done && groups > 0 && cyc == 20) begin
                bus.start = 1'b1; bus.quant_mode_cfg = ~mode; bus.num_groups = '0;
                tick_cycle();
                bus.start = 1'b0;
                spur_done = 1;
            end
            if (rst_at > 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                tick_cycle();
                rst_n = 1'b1;
                flush();
                busy_hi = tick;
                rst_at = 0;
            end
            tick_cycle();
            budget++;
        end
        check("done_within_budget", done_t.size(), 0);
        flush();
        repeat (2) tick_cycle();
        check("leftover_events", rd_t.size() + chg_t.size() + chn_t.size(), 0);
        check("read_count", rd_count, exp_reads);
        rd_t.delete(); rd_a.delete(); chg_t.delete(); chn_t.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at tick %0d", tick);
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        bus.clk_en = 1'b1; bus.start = 1'b0; bus.quant_mode_cfg = 1'b0;
        bus.num_groups = '0; bus.base_addr = '0; bus.infms_data_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick_cycle();
        rst_n = 1'b1;
        tick_cycle();

        run_job(1'b0, 1, 16'h0000, 5, 1'b0, 0, 0);     // INT4, one group
        run_job(1'b1, 2, 16'h1230, 7, 1'b0, 0, 0);     // INT8, two groups
        run_job(1'b0, 0, 16'h0055, 1, 1'b0, 0, 0);     // zero groups
        run_job(1'b0, 2, 16'h0100, 1, 1'b1, 0, 0);     // timeout abandons group 2
        repeat (3) tick_cycle();
        check("err_sticky", bus.err, 1'b1);
        run_job(1'b0, 1, 16'hFFFE, 3, 1'b0, 2, 0);     // wrap + clk_en stall
        run_job(1'b0, 1, 16'h0200, 30, 1'b0, 0, 144);  // reset during WAIT_CORE
        run_job(1'b1, 1, 16'h0300, 4, 1'b0, 0, 0);     // new config after reset
        for (int i = 0; i < 3; i++) begin
            m = 1'($urandom);
            run_job(m, 1 + int'($urandom_range(0, 1)), AW'($urandom),
                    1 + int'($urandom_range(0, 19)), 1'b0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
